// File: rtl/bias_stream_ctrl_pkg.sv
// Shared types for the bias ROM streaming controller: FSM encoding and sizing helpers.
package bias_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Depth of the skid buffer that absorbs ROM latency plus one stalled word.
  localparam int unsigned SKID_DEPTH = 2;

  // Address/counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned width_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bias_skid_fifo.sv
// Two-entry register FIFO. r_head is always the oldest word and drives the
// stream directly; r_tail holds the second word while the consumer stalls.
module bias_skid_fifo
  import bias_stream_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
)(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [1:0]            o_occ
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_occ;

  // Storage update; a simultaneous push and pop keeps the occupancy unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= i_din;
          else               r_tail <= i_din;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          if (r_occ == 2'd2) r_head <= r_tail;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_head <= r_tail;
            r_tail <= i_din;
          end else begin
            r_head <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head = r_head;
  assign o_occ  = r_occ;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_pop && (r_occ == 2'(SKID_DEPTH))));
  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_pop && (r_occ == 2'd0)));

endmodule

// File: rtl/bias_stream_ctrl.sv
// Bias ROM sequencer: replays MEM_SIZE ROM words REPEAT times per ap_start into
// the output FIFO, hiding the 1-cycle ROM latency behind a 2-entry skid buffer.
//
// Stream handshake: a word moves on output_V_write, which is asserted exactly
// when the buffer holds a word and output_V_full_n is high; output_V_din is the
// buffer head and stays stable while full_n is low.
module bias_stream_ctrl
  import bias_stream_ctrl_pkg::*;
#(
  parameter int unsigned MEM_SIZE   = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned REPEAT     = 1,
  localparam int unsigned AW        = width_min1(MEM_SIZE)
)(
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic [AW-1:0]         bias_address,
  output logic                  bias_ce,
  input  logic [DATA_WIDTH-1:0] bias_q,
  output logic [DATA_WIDTH-1:0] output_V_din,
  input  logic                  output_V_full_n,
  output logic                  output_V_write,
  output state_t                o_dbg_state
);

  localparam int unsigned PW = width_min1(REPEAT);

  state_t                r_state;
  state_t                w_next;
  logic [AW-1:0]         r_addr;
  logic [PW-1:0]         r_pass;
  logic                  r_inflight;

  logic [1:0]            w_occ;
  logic [DATA_WIDTH-1:0] w_head;
  logic [1:0]            w_pending;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_ce;
  logic                  w_addr_last;
  logic                  w_pass_last;
  logic                  w_last_read;
  logic                  w_drained;

  // A word leaves whenever one is buffered and the FIFO has room.
  assign w_pop = (w_occ != 2'd0) && output_V_full_n;

  // Credit: buffered words plus the word still coming from the ROM must fit in
  // the two slots, counting a slot freed by this cycle's pop.
  assign w_pending = w_occ + {1'b0, r_inflight};
  assign w_credit  = (w_pending < 2'd2) || ((w_pending == 2'd2) && w_pop);
  assign w_ce      = (r_state == ST_RUN) && w_credit;

  assign w_addr_last = (r_addr == AW'(MEM_SIZE - 1));
  assign w_pass_last = (r_pass == PW'(REPEAT - 1));
  assign w_last_read = w_ce && w_addr_last && w_pass_last;

  // Drain finishes on the edge that removes the final buffered word, so the
  // done pulse coincides with the cycle right after the last write.
  assign w_drained = !r_inflight &&
                     ((w_occ == 2'd0) || ((w_occ == 2'd1) && w_pop));

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  // Next-state and Moore handshake outputs.
  always_comb begin
    w_next   = r_state;
    ap_idle  = 1'b0;
    ap_done  = 1'b0;
    ap_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_last_read) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_drained) w_next = ST_DONE;
      end
      ST_DONE: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Address and pass counters advance per issued read; both wrap to 0 after the last read.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_addr <= '0;
      r_pass <= '0;
    end else if (r_state == ST_IDLE) begin
      r_addr <= '0;
      r_pass <= '0;
    end else if (w_ce) begin
      if (w_addr_last) begin
        r_addr <= '0;
        r_pass <= w_pass_last ? '0 : r_pass + 1'b1;
      end else begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // Marks that the ROM returns a word next cycle; cleared by reset so that word is dropped.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_inflight <= 1'b0;
    else           r_inflight <= w_ce;
  end

  bias_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk   (ap_clk),
    .i_rst_n (ap_rst_n),
    .i_push  (r_inflight),
    .i_din   (bias_q),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_occ   (w_occ)
  );

  assign bias_address   = r_addr;
  assign bias_ce        = w_ce;
  assign output_V_din   = w_head;
  assign output_V_write = w_pop;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_bias_stream_ctrl.sv
// Bench for bias_stream_ctrl: a MEM_SIZE=4/REPEAT=3 instance with a scoreboard
// and a MEM_SIZE=1/REPEAT=5 instance with directed cycle checks.
module tb_bias_stream_ctrl;

  localparam int DW  = 16;
  localparam int MS4 = 4;
  localparam int RP4 = 3;
  localparam int MS1 = 1;
  localparam int RP1 = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (4 x 3) ----------------
  logic          start4 = 1'b0;
  logic          full4  = 1'b1;
  logic          idle4, done4, ready4, ce4, wr4;
  logic [1:0]    addr4;
  logic [1:0]    dbg4;
  logic [DW-1:0] q4 = '0;
  logic [DW-1:0] din4;
  logic [DW-1:0] rom4 [MS4];

  bias_stream_ctrl #(.MEM_SIZE(MS4), .DATA_WIDTH(DW), .REPEAT(RP4)) u_dut4 (
    .ap_clk          (clk),
    .ap_rst_n        (rst_n),
    .ap_start        (start4),
    .ap_idle         (idle4),
    .ap_done         (done4),
    .ap_ready        (ready4),
    .bias_address    (addr4),
    .bias_ce         (ce4),
    .bias_q          (q4),
    .output_V_din    (din4),
    .output_V_full_n (full4),
    .output_V_write  (wr4),
    .o_dbg_state     (dbg4)
  );

  // ---------------- DUT B (1 x 5) ----------------
  logic          start1 = 1'b0;
  logic          full1  = 1'b1;
  logic          idle1, done1, ready1, ce1, wr1;
  logic [0:0]    addr1;
  logic [1:0]    dbg1;
  logic [DW-1:0] q1 = '0;
  logic [DW-1:0] din1;
  logic [DW-1:0] rom1_word;

  bias_stream_ctrl #(.MEM_SIZE(MS1), .DATA_WIDTH(DW), .REPEAT(RP1)) u_dut1 (
    .ap_clk          (clk),
    .ap_rst_n        (rst_n),
    .ap_start        (start1),
    .ap_idle         (idle1),
    .ap_done         (done1),
    .ap_ready        (ready1),
    .bias_address    (addr1),
    .bias_ce         (ce1),
    .bias_q          (q1),
    .output_V_din    (din1),
    .output_V_full_n (full1),
    .output_V_write  (wr1),
    .o_dbg_state     (dbg1)
  );

  // Synchronous ROM models: data valid the cycle after the read enable.
  always @(posedge clk) begin
    if (ce4) q4 <= rom4[addr4];
    if (ce1) q1 <= rom1_word;
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int n_cmp     = 0;
  int n_err     = 0;
  int done_cnt  = 0;
  int exp_done  = 0;
  int fn_mode   = 0;
  int occ_m     = 0;
  logic          inflight_m = 1'b0;
  logic          hold_m     = 1'b0;
  logic [DW-1:0] din_prev   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_run4();
    for (int p = 0; p < RP4; p++)
      for (int a = 0; a < MS4; a++)
        exp_q.push_back(rom4[a]);
  endtask

  // Pulses ap_start for one cycle (cycle 0); returns 1 ns into cycle 1.
  task automatic start_run4();
    push_run4();
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
  endtask

  task automatic wait_done4(input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      if (done4) seen = 1;
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic check_reset4(input string tag);
    chk({tag, "_idle"}, idle4, 1);
    chk({tag, "_done"}, done4, 0);
    chk({tag, "_ready"}, ready4, 0);
    chk({tag, "_ce"}, ce4, 0);
    chk({tag, "_addr"}, addr4, 0);
    chk({tag, "_write"}, wr4, 0);
    chk({tag, "_din"}, din4, 0);
  endtask

  // full_n pattern generator: 0 = high, 1 = toggle, 2 = low, 3 = random.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (fn_mode)
        0:       full4 = 1'b1;
        1:       full4 = ~full4;
        2:       full4 = 1'b0;
        default: full4 = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor / scoreboard for DUT A ----------------
  always @(negedge clk) begin
    logic pop_m;
    if (!rst_n) begin
      occ_m      = 0;
      inflight_m = 1'b0;
      hold_m     = 1'b0;
      exp_q.delete();
    end else begin
      pop_m = (occ_m != 0) && full4;
      chk("wr_strobe", wr4, pop_m);
      if (wr4) begin
        if (exp_q.size() == 0) chk("extra_write", 1, 0);
        else                   chk("data", din4, exp_q.pop_front());
      end
      if (ce4)
        chk("credit", ((occ_m + inflight_m) < 2) || (((occ_m + inflight_m) == 2) && pop_m), 1);
      if (idle4) chk("ce_in_idle", ce4, 0);
      if (hold_m) chk("hold_din", din4, din_prev);
      if (done4) begin
        chk("done_drained", exp_q.size(), 0);
        chk("ready_with_done", ready4, 1);
        done_cnt++;
      end
      hold_m     = (occ_m != 0) && !pop_m;
      din_prev   = din4;
      occ_m      = occ_m + int'(inflight_m) - int'(pop_m);
      inflight_m = ce4;
      if (occ_m > 2) chk("overflow", occ_m, 2);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int a = 0; a < MS4; a++) rom4[a] = DW'($urandom_range(0, 16'hFFFF));
    rom1_word = DW'($urandom_range(1, 16'hFFFF));

    // Reset values on both instances.
    repeat (3) @(negedge clk);
    check_reset4("rst");
    chk("rst1_idle", idle1, 1);
    chk("rst1_din", din1, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Exact latency and done timing: writes in cycles 3..14, done at 15, idle from 16.
    start_run4();
    exp_done++;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk("t_write", wr4, (k >= 3 && k <= 14));
      chk("t_done", done4, (k == 15));
      chk("t_ready", ready4, (k == 15));
      chk("t_idle", idle4, (k >= 16));
    end

    // Backpressure: toggling full_n, a 20-cycle stall, and a start pulse while running.
    fn_mode = 1;
    start_run4();
    exp_done++;
    repeat (3) @(posedge clk);
    #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    repeat (3) @(negedge clk);
    fn_mode = 2;
    repeat (20) @(negedge clk);
    fn_mode = 1;
    wait_done4(400);
    @(negedge clk);
    fn_mode = 0;
    repeat (5) @(negedge clk);
    chk("no_restart_idle", idle4, 1);

    // Reset in the middle of a pass, then a clean replay under random backpressure.
    start_run4();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #2 check_reset4("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    fn_mode = 3;
    start_run4();
    exp_done++;
    wait_done4(400);
    @(negedge clk);
    fn_mode = 0;
    repeat (3) @(negedge clk);

    // ap_start held high: the second run begins only after IDLE.
    push_run4();
    @(posedge clk); #1 start4 = 1'b1;
    wait_done4(200);
    exp_done++;
    @(negedge clk);
    chk("held_idle_gap", idle4, 1);
    push_run4();
    @(negedge clk);
    chk("held_restart", idle4, 0);
    @(posedge clk); #1 start4 = 1'b0;
    wait_done4(200);
    exp_done++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("held_after_idle", idle4, 1);
      chk("held_after_write", wr4, 0);
    end

    // MEM_SIZE=1, REPEAT=5: five writes in cycles 3..7, address pinned at 0, done at 8.
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("m1_addr", addr1, 0);
      chk("m1_write", wr1, (k >= 3 && k <= 7));
      if (wr1) chk("m1_data", din1, rom1_word);
      chk("m1_done", done1, (k == 8));
      chk("m1_idle", idle1, (k >= 9));
    end

    chk("done_count", done_cnt, exp_done);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
